// File: rtl/dsram_ctl_pkg.sv
// Shared types and constants for the L1 data-array arbiter.
package dsram_ctl_pkg;

   localparam int LINE_BITS = 256;
   localparam int BE_BITS   = 32;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_FILL = 1'b1
   } owner_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/dsram_arb_if.sv
// Requester-side bundle: the core load/store port and the fill/writeback port.
interface dsram_arb_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int WAY_W      = 2
);
   import dsram_ctl_pkg::*;

   logic                  core_req;
   logic                  core_we;
   logic [WAY_W-1:0]      core_way;
   logic [ADDR_WIDTH-1:0] core_a;
   logic [BE_BITS-1:0]    core_be;
   logic [LINE_BITS-1:0]  core_wd;
   logic                  core_gnt;
   logic                  core_rvalid;
   logic [LINE_BITS-1:0]  core_rdata;

   logic                  fill_req;
   logic                  fill_we;
   logic [WAY_W-1:0]      fill_way;
   logic [ADDR_WIDTH-1:0] fill_a;
   logic [BE_BITS-1:0]    fill_be;
   logic [LINE_BITS-1:0]  fill_wd;
   logic                  fill_lock;
   logic                  fill_gnt;
   logic                  fill_rvalid;
   logic [LINE_BITS-1:0]  fill_rdata;

   modport master (
      output core_req, core_we, core_way, core_a, core_be, core_wd,
      output fill_req, fill_we, fill_way, fill_a, fill_be, fill_wd, fill_lock,
      input  core_gnt, core_rvalid, core_rdata,
      input  fill_gnt, fill_rvalid, fill_rdata
   );

   modport slave (
      input  core_req, core_we, core_way, core_a, core_be, core_wd,
      input  fill_req, fill_we, fill_way, fill_a, fill_be, fill_wd, fill_lock,
      output core_gnt, core_rvalid, core_rdata,
      output fill_gnt, fill_rvalid, fill_rdata
   );

endinterface

// File: rtl/dsram_rdmux.sv
// WAYS:1 line mux picking the returning way's read data.
module dsram_rdmux
   import dsram_ctl_pkg::*;
#(
   parameter int WAYS  = 4,
   parameter int WAY_W = 2
) (
   input  logic [WAYS*LINE_BITS-1:0] sram_rd,
   input  logic [WAY_W-1:0]          sel,
   output logic [LINE_BITS-1:0]      line
);

   always_comb begin
      line = sram_rd[int'(sel)*LINE_BITS +: LINE_BITS];
   end

endmodule

// File: rtl/dsram_arb.sv
// Single-slot arbiter for the per-way L1 data arrays: core vs fill engine,
// with fill lock-out sequences and a starvation guard for the core.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | fill has priority; core forced through after STARVE_MAX
//   ST_LOCKED | fill owns the arrays; core blocked, starve count frozen
module dsram_arb
   import dsram_ctl_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int WAYS       = 4,
   parameter int WAY_W      = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   dsram_arb_if.slave                 bus,
   output logic                       locked,
   output logic [ADDR_WIDTH-1:0]      sram_a,
   output logic [BE_BITS-1:0]         sram_be,
   output logic [LINE_BITS-1:0]       sram_wd,
   output logic [WAYS-1:0]            sram_write,
   output logic [WAYS-1:0]            sram_read,
   input  logic [WAYS*LINE_BITS-1:0]  sram_rd
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic               locked_q, locked_d;
   logic               rvalid_q, rvalid_d;
   owner_e             rd_own_q, rd_own_d;
   logic [WAY_W-1:0]   rd_way_q, rd_way_d;

   logic               starved;
   logic               core_win;
   logic               fill_win;
   logic               any_win;
   logic               acc_we;
   logic [WAY_W-1:0]   acc_way;
   logic [BE_BITS-1:0] acc_be;
   logic [WAYS-1:0]    way_oh;
   logic [LINE_BITS-1:0] rd_line;

   always_comb begin
      starved  = (starve_cnt_q == CNT_W'(STARVE_MAX));
      core_win = 1'b0;
      fill_win = 1'b0;
      if (state_q == ST_LOCKED) begin
         fill_win = bus.fill_req;
      end else if (starved && bus.core_req) begin
         core_win = 1'b1;
      end else if (bus.fill_req) begin
         fill_win = 1'b1;
      end else begin
         core_win = bus.core_req;
      end
      any_win = core_win | fill_win;
   end

   assign bus.core_gnt = core_win;
   assign bus.fill_gnt = fill_win;

   // Shared array port; read accesses never carry byte enables to the array.
   always_comb begin
      sram_a     = fill_win ? bus.fill_a   : bus.core_a;
      sram_wd    = fill_win ? bus.fill_wd  : bus.core_wd;
      acc_we     = fill_win ? bus.fill_we  : bus.core_we;
      acc_way    = fill_win ? bus.fill_way : bus.core_way;
      acc_be     = fill_win ? bus.fill_be  : bus.core_be;
      way_oh     = WAYS'(1) << acc_way;
      sram_be    = (any_win && acc_we) ? acc_be : '0;
      sram_write = (any_win && acc_we)  ? way_oh : '0;
      sram_read  = (any_win && !acc_we) ? way_oh : '0;
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (fill_win && bus.fill_lock) state_d = ST_LOCKED;
            if (core_win || !bus.core_req) begin
               starve_cnt_d = '0;
            end else if (!starved) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!bus.fill_lock) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      locked_d = (state_d == ST_LOCKED);
      rvalid_d = any_win && !acc_we;
      rd_own_d = rd_own_q;
      rd_way_d = rd_way_q;
      if (rvalid_d) begin
         rd_own_d = fill_win ? OWN_FILL : OWN_CORE;
         rd_way_d = acc_way;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= '0;
         locked_q     <= 1'b0;
         rvalid_q     <= 1'b0;
         rd_own_q     <= OWN_CORE;
         rd_way_q     <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         locked_q     <= locked_d;
         rvalid_q     <= rvalid_d;
         rd_own_q     <= rd_own_d;
         rd_way_q     <= rd_way_d;
      end
   end

   dsram_rdmux #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_rdmux (
      .sram_rd (sram_rd),
      .sel     (rd_way_q),
      .line    (rd_line)
   );

   assign locked          = locked_q;
   assign bus.core_rvalid = rvalid_q && (rd_own_q == OWN_CORE);
   assign bus.fill_rvalid = rvalid_q && (rd_own_q == OWN_FILL);
   assign bus.core_rdata  = rd_line;
   assign bus.fill_rdata  = rd_line;

endmodule

// File: tb/tb_dsram_arb.sv
// Bench for dsram_arb: per-cycle vector table plus read-return scoreboard
// against a behavioural 4-way array with 1-cycle read latency.
module tb_dsram_arb;
   import dsram_ctl_pkg::*;

   localparam int AW = 13;
   localparam logic [255:0] CORE_WD = {256{1'b1}};
   localparam logic [255:0] FILL_WD = {8{32'hDEAD_BEEF}};
   localparam logic [31:0]  BX      = 32'hFFFF_FFFF;

   typedef struct {
      logic          rst;
      logic          cr, cw;
      logic [1:0]    cway;
      logic [AW-1:0] ca;
      logic [31:0]   cbe;
      logic          fr, fw;
      logic [1:0]    fway;
      logic [AW-1:0] fa;
      logic [31:0]   fbe;
      logic          fl;
      logic          cg, fg;
      logic [3:0]    rd, wr;
      logic [31:0]   ebe;
      logic [AW-1:0] ea;
      logic          lk;
   } vec_t;

   typedef struct {
      owner_e       own;
      logic [255:0] data;
      int           due;
   } sb_t;

   logic           clk;
   logic           reset;
   logic           locked;
   logic [AW-1:0]  sram_a;
   logic [31:0]    sram_be;
   logic [255:0]   sram_wd;
   logic [3:0]     sram_write;
   logic [3:0]     sram_read;
   logic [1023:0]  sram_rd;

   logic [255:0]   mem [4][16];
   logic [255:0]   rd_q [4];
   logic [255:0]   ref_mem [4][16];
   logic           mem_init;
   logic           started;
   int             cyc;
   int             tests;
   int             fails;
   sb_t            sbq[$];
   vec_t           tbl[$];

   dsram_arb_if #(.ADDR_WIDTH(AW), .WAY_W(2)) ifc ();

   dsram_arb #(
      .ADDR_WIDTH (AW),
      .WAYS       (4),
      .WAY_W      (2),
      .STARVE_MAX (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (ifc),
      .locked     (locked),
      .sram_a     (sram_a),
      .sram_be    (sram_be),
      .sram_wd    (sram_wd),
      .sram_write (sram_write),
      .sram_read  (sram_read),
      .sram_rd    (sram_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] pat(input int w, input int a);
      logic [7:0] b;
      b = 8'(16 * w + a + 1);
      if (w == 2 && a == 5) b = 8'hA5;
      return {32{b}};
   endfunction

   function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                          input logic [31:0] be);
      logic [255:0] r;
      r = old;
      for (int b = 0; b < 32; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // Behavioural array: registered read port, byte-masked write.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_init) begin
         for (int w = 0; w < 4; w++)
            for (int a = 0; a < 16; a++) mem[w][a] <= pat(w, a);
      end else begin
         for (int w = 0; w < 4; w++) begin
            if (sram_write[w]) mem[w][sram_a[3:0]] <= merge(mem[w][sram_a[3:0]], sram_wd, sram_be);
            if (sram_read[w])  rd_q[w] <= mem[w][sram_a[3:0]];
         end
      end
   end

   always_comb sram_rd = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      sb_t  e;
      logic exp_c, exp_f;
      if (started) begin
         exp_c = 1'b0;
         exp_f = 1'b0;
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e     = sbq.pop_front();
            exp_c = (e.own == OWN_CORE);
            exp_f = (e.own == OWN_FILL);
         end
         chk($sformatf("c%0d core_rvalid", cyc), 256'(ifc.core_rvalid), 256'(exp_c));
         chk($sformatf("c%0d fill_rvalid", cyc), 256'(ifc.fill_rvalid), 256'(exp_f));
         if (exp_c) chk($sformatf("c%0d core_rdata", cyc), ifc.core_rdata, e.data);
         if (exp_f) chk($sformatf("c%0d fill_rdata", cyc), ifc.fill_rdata, e.data);
      end
   end

   function automatic vec_t mkv(
      input logic cr, input logic cw, input logic [1:0] cway, input logic [AW-1:0] ca,
      input logic [31:0] cbe,
      input logic fr, input logic fw, input logic [1:0] fway, input logic [AW-1:0] fa,
      input logic [31:0] fbe, input logic fl,
      input logic cg, input logic fg, input logic [3:0] rd, input logic [3:0] wr,
      input logic [31:0] ebe, input logic [AW-1:0] ea, input logic lk);
      vec_t v;
      v.rst = 1'b0;
      v.cr = cr; v.cw = cw; v.cway = cway; v.ca = ca; v.cbe = cbe;
      v.fr = fr; v.fw = fw; v.fway = fway; v.fa = fa; v.fbe = fbe; v.fl = fl;
      v.cg = cg; v.fg = fg; v.rd = rd; v.wr = wr; v.ebe = ebe; v.ea = ea; v.lk = lk;
      return v;
   endfunction

   // Drive one cycle just after the edge, book expected returns, check at negedge.
   task automatic do_cycle(input vec_t v, input string tag);
      reset         = v.rst;
      ifc.core_req  = v.cr;  ifc.core_we = v.cw;  ifc.core_way = v.cway;
      ifc.core_a    = v.ca;  ifc.core_be = v.cbe; ifc.core_wd  = CORE_WD;
      ifc.fill_req  = v.fr;  ifc.fill_we = v.fw;  ifc.fill_way = v.fway;
      ifc.fill_a    = v.fa;  ifc.fill_be = v.fbe; ifc.fill_wd  = FILL_WD;
      ifc.fill_lock = v.fl;
      if (!v.rst) begin
         if (v.cg && !v.cw) sbq.push_back('{OWN_CORE, ref_mem[v.cway][v.ca[3:0]], cyc + 1});
         if (v.cg && v.cw)  ref_mem[v.cway][v.ca[3:0]] = merge(ref_mem[v.cway][v.ca[3:0]], CORE_WD, v.cbe);
         if (v.fg && !v.fw) sbq.push_back('{OWN_FILL, ref_mem[v.fway][v.fa[3:0]], cyc + 1});
         if (v.fg && v.fw)  ref_mem[v.fway][v.fa[3:0]] = merge(ref_mem[v.fway][v.fa[3:0]], FILL_WD, v.fbe);
      end
      @(negedge clk);
      chk({tag, " core_gnt"},   256'(ifc.core_gnt), 256'(v.cg));
      chk({tag, " fill_gnt"},   256'(ifc.fill_gnt), 256'(v.fg));
      chk({tag, " sram_read"},  256'(sram_read),    256'(v.rd));
      chk({tag, " sram_write"}, 256'(sram_write),   256'(v.wr));
      chk({tag, " locked"},     256'(locked),       256'(v.lk));
      if (v.cg || v.fg) begin
         chk({tag, " sram_a"},  256'(sram_a),  256'(v.ea));
         chk({tag, " sram_be"}, 256'(sram_be), 256'(v.ebe));
      end
      if (v.cg && v.cw) chk({tag, " sram_wd"}, sram_wd, CORE_WD);
      if (v.fg && v.fw) chk({tag, " sram_wd"}, sram_wd, FILL_WD);
      @(posedge clk);
      #1;
   endtask

   // Fill and core both requesting from a clean IDLE: 8 fill grants, then the core.
   task automatic run_starve(input string tag);
      for (int i = 0; i < 10; i++) begin
         do_cycle(mkv(1, 0, 1, 2, 0,  1, 0, 0, 1, 0, 0,
                      i == 8, i != 8, (i == 8) ? 4'b0010 : 4'b0001, 4'b0000, 0,
                      (i == 8) ? AW'(2) : AW'(1), 0),
                  $sformatf("%s%0d", tag, i));
      end
   endtask

   initial begin
      vec_t r;
      tests = 0; fails = 0; cyc = 0; started = 1'b0;
      reset = 1'b1; mem_init = 1'b1;
      ifc.core_req = 0; ifc.core_we = 0; ifc.core_way = 0; ifc.core_a = 0;
      ifc.core_be = 0; ifc.core_wd = 0;
      ifc.fill_req = 0; ifc.fill_we = 0; ifc.fill_way = 0; ifc.fill_a = 0;
      ifc.fill_be = 0; ifc.fill_wd = 0; ifc.fill_lock = 0;
      for (int w = 0; w < 4; w++)
         for (int a = 0; a < 16; a++) ref_mem[w][a] = pat(w, a);

      //          cr cw wy a  cbe         fr fw wy a  fbe           fl  cg fg rd       wr       ebe            ea lk
      tbl.push_back(mkv(0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0,  0, 0, 4'b0000, 4'b0000, 0,             0, 0));
      tbl.push_back(mkv(1, 0, 2, 5, BX,           0, 0, 0, 0, 0,            0,  1, 0, 4'b0100, 4'b0000, 0,             5, 0));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            1, 0, 1, 7, BX,           0,  0, 1, 4'b0010, 4'b0000, 0,             7, 0));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            0, 0, 0, 0, 0,            0,  1, 0, 4'b0100, 4'b0000, 0,             5, 0));
      tbl.push_back(mkv(1, 1, 0, 3, 32'hF,        0, 0, 0, 0, 0,            0,  1, 0, 4'b0000, 4'b0001, 32'hF,         3, 0));
      tbl.push_back(mkv(1, 0, 0, 3, 0,            0, 0, 0, 0, 0,            0,  1, 0, 4'b0001, 4'b0000, 0,             3, 0));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            1, 0, 1, 7, 0,            1,  0, 1, 4'b0010, 4'b0000, 0,             7, 0));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            1, 0, 2, 6, 0,            1,  0, 1, 4'b0100, 4'b0000, 0,             6, 1));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            1, 0, 3, 9, 0,            1,  0, 1, 4'b1000, 4'b0000, 0,             9, 1));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            1, 0, 1, 8, 0,            1,  0, 1, 4'b0010, 4'b0000, 0,             8, 1));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            0, 0, 0, 0, 0,            1,  0, 0, 4'b0000, 4'b0000, 0,             0, 1));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            0, 0, 0, 0, 0,            0,  0, 0, 4'b0000, 4'b0000, 0,             0, 1));
      tbl.push_back(mkv(1, 0, 2, 5, 0,            0, 0, 0, 0, 0,            0,  1, 0, 4'b0100, 4'b0000, 0,             5, 0));
      tbl.push_back(mkv(0, 0, 0, 0, 0,            1, 1, 3, 9, 32'h0000_FF00, 0, 0, 1, 4'b0000, 4'b1000, 32'h0000_FF00, 9, 0));
      tbl.push_back(mkv(0, 0, 0, 0, 0,            1, 0, 3, 9, BX,           0,  0, 1, 4'b1000, 4'b0000, 0,             9, 0));

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; mem_init = 1'b0; started = 1'b1;

      for (int i = 0; i < tbl.size(); i++) do_cycle(tbl[i], $sformatf("v%0d", i));

      run_starve("starve");
      do_cycle(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), "gap");

      // Build up starve count, enter LOCKED, then reset on a pending evict read.
      for (int i = 0; i < 5; i++)
         do_cycle(mkv(1, 0, 1, 2, 0, 1, 0, 0, 1, 0, 0, 0, 1, 4'b0001, 4'b0000, 0, 1, 0),
                  $sformatf("pre%0d", i));
      do_cycle(mkv(1, 0, 1, 2, 0, 1, 0, 1, 7, 0, 1, 0, 1, 4'b0010, 4'b0000, 0, 7, 0), "lock");
      r = mkv(1, 0, 1, 2, 0, 1, 0, 3, 9, 0, 1, 0, 1, 4'b1000, 4'b0000, 0, 9, 1);
      r.rst = 1'b1;
      do_cycle(r, "rst");
      run_starve("post");
      do_cycle(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0), "end");

      chk("sb_drained", 256'(sbq.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dsram_arb.md
Name: dsram_arb

Overview:
- Arbiter and sequencer in front of the per-way L1 data arrays (one dsram instance per way, 256-bit line, 32 byte enables, 1-cycle read latency).
- Shares the single array access slot per cycle between two requesters:
  - the core load/store port;
  - the fill/writeback engine, which may lock the arrays for multi-cycle evict+fill sequences.
- Routes read data back to the owner with a valid strobe, and prevents starvation of the core.

Parameters:
- ADDR_WIDTH, 13: array index width; matches dsram ADDR_WIDTH.
- WAYS, 4: number of data-array ways.
- WAY_W, 2: way select width, equal to log2(WAYS).
- STARVE_MAX, 8: consecutive core-denied cycles before the core is forced a grant.

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_way  in  WAY_W  target way.
- core_a  in  ADDR_WIDTH  line index.
- core_be  in  32  byte enables (writes only).
- core_wd  in  256  write data.
- core_gnt  out  1  combinational grant; the request is consumed this cycle.
- core_rvalid  out  1  read data valid, one cycle after a read grant.
- core_rdata  out  256  read data.
- fill_req, fill_we, fill_way, fill_a, fill_be, fill_wd  in  same widths as the core_* equivalents  fill/evict access.
- fill_lock  in  1  request exclusive ownership of the arrays.
- fill_gnt  out  1  combinational grant.
- fill_rvalid  out  1  evict read data valid.
- fill_rdata  out  256  evict read data.
- locked  out  1  registered; 1 while in the LOCKED state.
- sram_a  out  ADDR_WIDTH  shared array index.
- sram_be  out  32  shared byte enables.
- sram_wd  out  256  shared write data.
- sram_write  out  WAYS  one-hot per-way write strobe.
- sram_read  out  WAYS  one-hot per-way read strobe.
- sram_rd  in  WAYS*256  per-way read data; way w occupies bits [w*256+255 : w*256].

Behaviour:
- Reset values: state IDLE, starve_cnt 0, core_rvalid 0, fill_rvalid 0, locked 0. sram_write and sram_read are 0 whenever there is no grant. rdata outputs are don't-care while their rvalid is 0.
- At most one grant per cycle.
- A granted access drives sram_a/be/wd from the winner. Exactly one bit of sram_write (we=1) or sram_read (we=0) is set, at index way.
- For a write, sram_be is passed through unchanged. For a read, sram_be is forced to 0.
- States and transitions:
  - IDLE:
    - Default priority is fill over core.
    - Exception: if starve_cnt == STARVE_MAX and core_req, the core wins and starve_cnt clears.
    - If fill is granted with fill_lock=1, next state is LOCKED.
  - LOCKED:
    - Only fill may be granted; core_gnt=0 and starve_cnt is frozen.
    - The cycle fill_lock is sampled 0, next state is IDLE. No grant is required for that exit.
- starve_cnt, in IDLE:
  - increments when core_req=1 and core_gnt=0, saturating at STARVE_MAX;
  - clears on core_gnt or when core_req=0.
- Read return:
  - Register owner, way and a read flag at the grant edge.
  - In the next cycle, assert the owner's rvalid for exactly one cycle.
  - rdata is the sram_rd slice selected by the registered way.
  - Back-to-back read grants give back-to-back rvalid.
- Write then read of the same way and index in the next cycle returns the new data; the array guarantees this. No forwarding is needed in this block.
- Reset asserted mid-operation: the same edge clears state, locked and the rvalid flags. A read return pending at reset is dropped.
- A request with we=0 and be≠0 is legal; the be value is ignored.

Decomposition:
- Package dsram_ctl_pkg holds:
  - LINE_BITS=256 and BE_BITS=32;
  - owner encoding: OWN_CORE=0, OWN_FILL=1;
  - state encoding: ST_IDLE=0, ST_LOCKED=1.
- One natural sub-module: dsram_rdmux, a combinational WAYS:1 line mux selected by the registered way. Everything else stays in dsram_arb.

Test Plan:
- Read return path:
  - Stimulus: after reset, core read way 2, a=5, where the array holds 0xA5 repeated.
  - Required: core_gnt=1 in that cycle; sram_read=4'b0100; next cycle core_rvalid=1 with core_rdata=0xA5 repeated; fill_rvalid=0.
- Simultaneous requests:
  - Stimulus: core and fill request in the same cycle, no lock.
  - Required: fill_gnt=1, core_gnt=0. The next cycle, with fill_req dropped, grants the core.
- Starvation override:
  - Stimulus: fill_req held high continuously with core_req also high.
  - Required: core_gnt=0 for 8 cycles, core_gnt=1 on the 9th cycle, then fill is granted again.
- Lock sequence:
  - Stimulus: fill_lock=1 with 4 evict reads; core_req high throughout.
  - Required: locked=1 from the cycle after the first grant; core_gnt=0 throughout; fill_rvalid pulses 4 times. When fill_lock drops, locked=0 the next cycle and the core is granted.
- Partial write:
  - Stimulus: core write way 0, a=3, be=32'h0000_000F, wd=all 1s; then a read of the same line.
  - Required: sram_be=0xF on the write; bytes 0-3 read back as 0xFF and the other bytes are unchanged.
- Reset mid-operation:
  - Stimulus: reset asserted the cycle after a read grant, while in LOCKED.
  - Required: no rvalid the next cycle; locked=0, state IDLE, starve_cnt=0.
